// File: rtl/reset_sequencer_pkg.sv
// Shared state encoding and counter sizing helpers for the reset sequencer.
// Pure definitions: no logic, no latency, no backpressure.
package reset_sequencer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_ASSERT    = 2'd0;
  localparam state_t ST_WAIT_LOCK = 2'd1;
  localparam state_t ST_RELEASE   = 2'd2;
  localparam state_t ST_RUN       = 2'd3;

  // One shared counter serves all three timed phases, so size it for the longest.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for a single asynchronous level, parameterized reset value.
// Latency 2 clk edges; no backpressure.
module bit_synchronizer #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_synchronizer.sv
// Reset synchronizer: asserts asynchronously, releases on the 2nd clk edge after rst_n rises.
// Latency 2 clk edges on release, none on assertion; no backpressure.
module reset_synchronizer (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic stage1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1     <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      stage1     <= 1'b1;
      rst_sync_n <= stage1;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Holds downstream resets until PLL lock is filtered, then releases stages in order.
// Outputs registered; abort 1 edge after soft_reset, 3 edges after pll_locked falls; no backpressure.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int MIN_ASSERT  = 16,
  parameter int LOCK_FILTER = 8,
  parameter int STAGE_DELAY = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  soft_reset,
  output logic [NUM_STAGES-1:0] stage_reset_n,
  output logic                  sequence_done,
  output logic                  lock_lost
);

  localparam int CW = cnt_width(MIN_ASSERT, LOCK_FILTER, STAGE_DELAY);
  localparam int IW = idx_width(NUM_STAGES);

  localparam logic [CW-1:0] MA_LAST  = CW'(MIN_ASSERT - 1);
  localparam logic [CW-1:0] LF_LAST  = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] SD_LAST  = CW'(STAGE_DELAY - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_STAGES - 1);

  logic                  rst_int_n;
  logic                  lock_s;
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [NUM_STAGES-1:0] rel_mask;

  reset_synchronizer u_rst_sync (
    .clk        (clk),
    .rst_n      (reset_n),
    .rst_sync_n (rst_int_n)
  );

  // Cleared directly by reset_n so lock is already qualified when the FSM starts counting.
  bit_synchronizer #(.RESET_VAL(1'b0)) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  assign rel_mask = NUM_STAGES'(1) << idx;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state         <= ST_ASSERT;
      cnt           <= '0;
      idx           <= '0;
      stage_reset_n <= '0;
      sequence_done <= 1'b0;
      lock_lost     <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      case (state)
        ST_ASSERT: begin
          if (soft_reset) begin
            cnt <= '0;
          end else if (cnt == MA_LAST) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          if (soft_reset) begin
            state <= ST_ASSERT;
            cnt   <= '0;
          end else if (!lock_s) begin
            cnt <= '0;
          end else if (cnt == LF_LAST) begin
            state <= ST_RELEASE;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (soft_reset || !lock_s) begin
            state         <= ST_ASSERT;
            cnt           <= '0;
            idx           <= '0;
            stage_reset_n <= '0;
            sequence_done <= 1'b0;
          end else if (cnt == SD_LAST) begin
            stage_reset_n <= stage_reset_n | rel_mask;
            cnt           <= '0;
            if (idx == IDX_LAST) begin
              state         <= ST_RUN;
              sequence_done <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RUN: begin
          if (soft_reset || !lock_s) begin
            state         <= ST_ASSERT;
            cnt           <= '0;
            idx           <= '0;
            stage_reset_n <= '0;
            sequence_done <= 1'b0;
            // A software request takes the blame, so no lock-loss report when both coincide.
            lock_lost     <= !soft_reset;
          end
        end

        default: begin
          state         <= ST_ASSERT;
          cnt           <= '0;
          idx           <= '0;
          stage_reset_n <= '0;
          sequence_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default-parameter DUT checked through a cycle-stamped scoreboard,
// plus a minimum-parameter DUT checked inline.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       soft_reset;
  logic [2:0] stage;
  logic       done;
  logic       lost;
  logic [0:0] stage1;
  logic       done1;
  logic       lost1;

  always #5 clk = ~clk;

  reset_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pll_locked    (pll_locked),
    .soft_reset    (soft_reset),
    .stage_reset_n (stage),
    .sequence_done (done),
    .lock_lost     (lost)
  );

  reset_sequencer #(
    .NUM_STAGES  (1),
    .MIN_ASSERT  (1),
    .LOCK_FILTER (1),
    .STAGE_DELAY (1)
  ) dut1 (
    .clk           (clk),
    .reset_n       (reset_n),
    .pll_locked    (pll_locked),
    .soft_reset    (soft_reset),
    .stage_reset_n (stage1),
    .sequence_done (done1),
    .lock_lost     (lost1)
  );

  typedef struct {
    int         cyc;
    logic [2:0] stg;
    logic       dn;
    logic       ll;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected values are stamped with the edge count after which they must hold.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      vectors++;
      if (mon_e.cyc != cyc) begin
        miscompares++;
        $display("FAIL sb_missed: entry for edge %0d seen at edge %0d", mon_e.cyc, cyc);
      end else if ({stage, done, lost} !== {mon_e.stg, mon_e.dn, mon_e.ll}) begin
        miscompares++;
        $display("FAIL sb@%0d: got stage=%b done=%b lost=%b, expected stage=%b done=%b lost=%b",
                 cyc, stage, done, lost, mon_e.stg, mon_e.dn, mon_e.ll);
      end
    end
  end

  function automatic void push(input int c, input logic [2:0] s, input logic d, input logic l);
    exp_t e;
    e.cyc = c;
    e.stg = s;
    e.dn  = d;
    e.ll  = l;
    sb.push_back(e);
  endfunction

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drain();
    int budget;
    budget = 400;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset(output int t0);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    t0 = cyc + 2;
  endtask

  task automatic test_reset();
    int t0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({stage, done, lost} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_state: got %b, expected 00000", {stage, done, lost});
    end
    vectors++;
    if ({stage1, done1, lost1} !== 3'b0) begin
      miscompares++;
      $display("FAIL reset_state_min: got %b, expected 000", {stage1, done1, lost1});
    end
    reset_n = 1'b1;
    t0 = cyc + 2;
    push(t0,      3'b000, 1'b0, 1'b0);
    push(t0 + 39, 3'b000, 1'b0, 1'b0);
    push(t0 + 40, 3'b001, 1'b0, 1'b0);
    push(t0 + 55, 3'b001, 1'b0, 1'b0);
    push(t0 + 56, 3'b011, 1'b0, 1'b0);
    push(t0 + 71, 3'b011, 1'b0, 1'b0);
    push(t0 + 72, 3'b111, 1'b1, 1'b0);
    wait_cyc(t0 + 2);
    vectors++;
    if ({stage1, done1} !== 2'b00) begin
      miscompares++;
      $display("FAIL min_pre_release: got %b, expected 00", {stage1, done1});
    end
    wait_cyc(t0 + 3);
    vectors++;
    if ({stage1, done1} !== 2'b11) begin
      miscompares++;
      $display("FAIL min_release: got %b, expected 11", {stage1, done1});
    end
    drain();
  endtask

  task automatic test_lock_glitch();
    int t0;
    do_reset(t0);
    push(t0 + 45, 3'b000, 1'b0, 1'b0);
    push(t0 + 46, 3'b001, 1'b0, 1'b0);
    push(t0 + 61, 3'b001, 1'b0, 1'b0);
    push(t0 + 62, 3'b011, 1'b0, 1'b0);
    push(t0 + 77, 3'b011, 1'b0, 1'b0);
    push(t0 + 78, 3'b111, 1'b1, 1'b0);
    wait_cyc(t0 + 19);
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    drain();
  endtask

  task automatic test_lock_loss();
    int l;
    l = cyc;
    push(l + 2,  3'b111, 1'b1, 1'b0);
    push(l + 3,  3'b000, 1'b0, 1'b1);
    push(l + 4,  3'b000, 1'b0, 1'b0);
    push(l + 42, 3'b000, 1'b0, 1'b0);
    push(l + 43, 3'b001, 1'b0, 1'b0);
    push(l + 59, 3'b011, 1'b0, 1'b0);
    push(l + 75, 3'b111, 1'b1, 1'b0);
    pll_locked = 1'b0;
    wait_cyc(l + 10);
    pll_locked = 1'b1;
    drain();
  endtask

  task automatic test_soft_reset();
    int s;
    s = cyc;
    push(s + 1,   3'b000, 1'b0, 1'b0);
    push(s + 2,   3'b000, 1'b0, 1'b0);
    push(s + 45,  3'b000, 1'b0, 1'b0);
    push(s + 69,  3'b000, 1'b0, 1'b0);
    push(s + 70,  3'b001, 1'b0, 1'b0);
    push(s + 86,  3'b011, 1'b0, 1'b0);
    push(s + 101, 3'b011, 1'b0, 1'b0);
    push(s + 102, 3'b111, 1'b1, 1'b0);
    soft_reset = 1'b1;
    wait_cyc(s + 30);
    soft_reset = 1'b0;
    drain();
  endtask

  task automatic test_simultaneous();
    int c;
    c = cyc;
    push(c + 2,  3'b111, 1'b1, 1'b0);
    push(c + 3,  3'b000, 1'b0, 1'b0);
    push(c + 4,  3'b000, 1'b0, 1'b0);
    push(c + 44, 3'b000, 1'b0, 1'b0);
    push(c + 45, 3'b001, 1'b0, 1'b0);
    push(c + 77, 3'b111, 1'b1, 1'b0);
    pll_locked = 1'b0;
    wait_cyc(c + 2);
    soft_reset = 1'b1;
    wait_cyc(c + 5);
    soft_reset = 1'b0;
    pll_locked = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid_release();
    int t0;
    do_reset(t0);
    wait_cyc(t0 + 45);
    vectors++;
    if ({stage, done} !== 4'b0010) begin
      miscompares++;
      $display("FAIL mid_release_pre: got %b, expected 0010", {stage, done});
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({stage, done, lost, stage1, done1, lost1} !== 8'b0) begin
      miscompares++;
      $display("FAIL async_clear: got %b, expected 00000000", {stage, done, lost, stage1, done1, lost1});
    end
    @(negedge clk);
    reset_n = 1'b1;
    t0 = cyc + 2;
    push(t0,      3'b000, 1'b0, 1'b0);
    push(t0 + 39, 3'b000, 1'b0, 1'b0);
    push(t0 + 40, 3'b001, 1'b0, 1'b0);
    push(t0 + 56, 3'b011, 1'b0, 1'b0);
    push(t0 + 72, 3'b111, 1'b1, 1'b0);
    drain();
  endtask

  initial begin
    reset_n    = 1'b0;
    pll_locked = 1'b1;
    soft_reset = 1'b0;
    test_reset();
    test_lock_glitch();
    test_lock_loss();
    test_soft_reset();
    test_simultaneous();
    test_reset_mid_release();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit at edge %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
